// File: rtl/servo_pkg.sv
// Shared servo definitions: datapath width, button FSM states and default timing.
// Used by servo_position_ctrl and by the downstream PWM stage.
package servo_pkg;

  localparam int W = 20;

  localparam int DEF_PERIOD    = 1_000_000;
  localparam int DEF_PULSE_MIN = 25_000;
  localparam int DEF_PULSE_MAX = 125_000;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT,
    LOCK
  } btn_state_e;

endpackage

// File: rtl/servo_btn_fsm.sv
// Pushbutton click/hold/autorepeat FSM with one shared hold timer.
// Emits single-cycle step_up / step_dn requests (combinational, one per accepted step).
module servo_btn_fsm
  import servo_pkg::*;
#(
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic btn_up_n,
  input  logic btn_down_n,
  output logic step_up,
  output logic step_dn
);

  localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  btn_state_e    state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic          dir_up, dir_up_next;
  logic          up, dn, held, both;

  assign up   = ~btn_up_n;
  assign dn   = ~btn_down_n;
  assign both = up & dn;
  assign held = dir_up ? up : dn;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      dir_up <= 1'b0;
    end else begin
      state  <= state_next;
      timer  <= timer_next;
      dir_up <= dir_up_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    timer_next  = timer + 1'b1;
    dir_up_next = dir_up;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          timer_next = '0;
          if (both) begin
            state_next = LOCK;
          end else if (up || dn) begin
            step_up     = up;
            step_dn     = dn;
            dir_up_next = up;
            state_next  = HELD;
          end
        end
        HELD, REPEAT: begin
          if (both) begin
            state_next = LOCK;
            timer_next = '0;
          end else if (!held) begin
            state_next = IDLE;
            timer_next = '0;
          end else if ((state == HELD   && timer == TW'(HOLD_CYC - 1)) ||
                       (state == REPEAT && timer == TW'(REPEAT_CYC - 1))) begin
            step_up    = dir_up;
            step_dn    = ~dir_up;
            timer_next = '0;
            state_next = REPEAT;
          end
        end
        LOCK: begin
          timer_next = '0;
          if (!up && !dn) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/servo_position_ctrl.sv
// Servo command stage: saturated target from buttons, per-frame slewed pulse width, frame strobe.
// Define SERVO_SLEW_EN to limit pulse_width changes to SLEW per frame; otherwise it jumps to target.
module servo_position_ctrl
  import servo_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int PULSE_MIN  = DEF_PULSE_MIN,
  parameter int PULSE_MAX  = DEF_PULSE_MAX,
  parameter int STEP       = 20_000,
  parameter int SLEW       = 2_500,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         btn_up_n,
  input  logic         btn_down_n,
  output logic [W-1:0] pulse_width,
  output logic [W-1:0] target_width,
  output logic         frame_start,
  output logic         at_min,
  output logic         at_max,
  output logic         busy
);

  if (PULSE_MAX >= PERIOD || PULSE_MIN >= PULSE_MAX || STEP < 1 || SLEW < 1) begin : g_bad_params
    $error("servo_position_ctrl: need PULSE_MIN < PULSE_MAX < PERIOD, STEP >= 1, SLEW >= 1");
  end

  localparam int CW = $clog2(PERIOD);
  typedef logic [W:0] wide_t;

  localparam logic [W-1:0] P_MIN = W'(PULSE_MIN);
  localparam logic [W-1:0] P_MAX = W'(PULSE_MAX);

  logic [CW-1:0] cnt;
  logic          step_up, step_dn;
  logic [W-1:0]  target_next, pulse_next, up_sat, dn_sat;
  wide_t         sum_up;
  logic signed [W:0] diff_dn;

  servo_btn_fsm #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_btn (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .btn_up_n  (btn_up_n),
    .btn_down_n(btn_down_n),
    .step_up   (step_up),
    .step_dn   (step_dn)
  );

  // One extra bit keeps the raw sum/difference exact before clamping.
  assign sum_up  = {1'b0, target_width} + wide_t'(STEP);
  assign diff_dn = $signed({1'b0, target_width}) - $signed(wide_t'(STEP));
  assign up_sat  = (sum_up > wide_t'(PULSE_MAX)) ? P_MAX : sum_up[W-1:0];
  assign dn_sat  = (diff_dn < $signed(wide_t'(PULSE_MIN))) ? P_MIN : diff_dn[W-1:0];

  always_comb begin
    target_next = target_width;
    if (step_up)      target_next = up_sat;
    else if (step_dn) target_next = dn_sat;

    // The slew tracks the registered target, so a step in a frame_start cycle waits a frame.
    pulse_next = pulse_width;
    if (frame_start) begin
`ifdef SERVO_SLEW_EN
      if (target_width > pulse_width) begin
        pulse_next = (target_width - pulse_width <= W'(SLEW)) ? target_width
                                                              : pulse_width + W'(SLEW);
      end else begin
        pulse_next = (pulse_width - target_width <= W'(SLEW)) ? target_width
                                                              : pulse_width - W'(SLEW);
      end
`else
      pulse_next = target_width;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      frame_start  <= 1'b0;
      target_width <= P_MIN;
      pulse_width  <= P_MIN;
      at_min       <= 1'b1;
      at_max       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (!enable) begin
        cnt         <= '0;
        frame_start <= 1'b0;
      end else begin
        cnt         <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
        frame_start <= (cnt == CW'(PERIOD - 1));
      end
      target_width <= target_next;
      pulse_width  <= pulse_next;
      at_min       <= (target_next == P_MIN);
      at_max       <= (target_next == P_MAX);
      busy         <= (pulse_next != target_next);
    end
  end

endmodule

// File: tb/tb_servo_position_ctrl.sv
// Directed bench for servo_position_ctrl with scaled-down timing parameters.
// Expectations follow the SERVO_SLEW_EN setting of the build.
module tb_servo_position_ctrl;

  localparam int P    = 2000;
  localparam int MIN  = 250;
  localparam int MAX  = 1250;
  localparam int STEP = 200;
  localparam int SLEW = 25;
  localparam int HOLD = 300;
  localparam int REP  = 60;

`ifdef SERVO_SLEW_EN
  localparam int NF = 8;
`else
  localparam int NF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, btn_up_n, btn_down_n;
  logic [19:0] pulse_width, target_width;
  logic        frame_start, at_min, at_max, busy;

  int errors = 0;
  int checks = 0;
  int n, exp, prev, p2, bad, nsteps;

  always #5 clk = ~clk;

  servo_position_ctrl #(
    .PERIOD(P), .PULSE_MIN(MIN), .PULSE_MAX(MAX), .STEP(STEP),
    .SLEW(SLEW), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .pulse_width(pulse_width), .target_width(target_width),
    .frame_start(frame_start), .at_min(at_min), .at_max(at_max), .busy(busy)
  );

  // Counts falling edges until frame_start is seen high; bounded.
  task automatic wait_frame(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (frame_start !== 1'b1 && cnt < 3 * P);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout: no frame_start within %0d cycles", cnt);
    end
  endtask

  task automatic click(input bit up, input int len);
    if (up) btn_up_n = 1'b0; else btn_down_n = 1'b0;
    repeat (len) @(negedge clk);
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; btn_up_n = 1'b1; btn_down_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pulse_width, target_width} !== {20'd250, 20'd250}) begin
      errors++;
      $display("FAIL reset_widths: got pulse=%0d target=%0d expected 250/250", pulse_width, target_width);
    end
    checks++;
    if ({at_min, at_max, busy, frame_start} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got min/max/busy/fs=%b expected 1000",
               {at_min, at_max, busy, frame_start});
    end
    rst_n = 1'b1;
    wait_frame(n);
    checks++;
    if (n !== P) begin errors++; $display("FAIL first_frame: got %0d cycles expected %0d", n, P); end
    checks++;
    if (pulse_width !== 20'd250) begin
      errors++; $display("FAIL idle_pulse: got %0d expected 250", pulse_width);
    end
    wait_frame(n);
    checks++;
    if (n !== P) begin errors++; $display("FAIL frame_period: got %0d cycles expected %0d", n, P); end
  endtask

  task automatic test_click;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_one_cycle: got %b expected 0", frame_start); end
    btn_up_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({target_width, pulse_width} !== {20'd450, 20'd250}) begin
      errors++;
      $display("FAIL click_step: got target=%0d pulse=%0d expected 450/250", target_width, pulse_width);
    end
    checks++;
    if ({at_min, busy} !== 2'b01) begin
      errors++; $display("FAIL click_flags: got min/busy=%b expected 01", {at_min, busy});
    end
    repeat (49) @(negedge clk);
    btn_up_n = 1'b1;
    prev = 250;
    for (int k = 1; k <= NF; k++) begin
      wait_frame(n);
      checks++;
      if (pulse_width !== 20'(prev)) begin
        errors++; $display("FAIL ramp_hold_%0d: got %0d expected %0d", k, pulse_width, prev);
      end
      @(negedge clk);
`ifdef SERVO_SLEW_EN
      exp = 250 + 25 * k;
`else
      exp = 450;
`endif
      checks++;
      if ({pulse_width, busy} !== {20'(exp), exp != 450}) begin
        errors++;
        $display("FAIL ramp_%0d: got pulse=%0d busy=%b expected %0d/%b", k, pulse_width, busy, exp, exp != 450);
      end
      prev = exp;
    end
    checks++;
    if (target_width !== 20'd450) begin
      errors++; $display("FAIL click_single: got target=%0d expected 450", target_width);
    end
  endtask

  task automatic test_hold;
    btn_up_n = 1'b0;
    for (int i = 1; i <= 450; i++) begin
      @(negedge clk);
      if (i == 1 || i == 300 || i == 301 || i == 360 || i == 361 ||
          i == 420 || i == 421 || i == 450) begin
        nsteps = 1 + int'(i > HOLD) + int'(i > HOLD + REP) + int'(i > HOLD + 2 * REP);
        exp = 450 + STEP * nsteps;
        if (exp > MAX) exp = MAX;
        checks++;
        if (target_width !== 20'(exp)) begin
          errors++; $display("FAIL hold_t%0d: got target=%0d expected %0d", i, target_width, exp);
        end
      end
    end
    btn_up_n = 1'b1;
    checks++;
    if ({at_max, at_min} !== 2'b10) begin
      errors++; $display("FAIL hold_at_max: got max/min=%b expected 10", {at_max, at_min});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturate;
    for (int c = 0; c < 2; c++) begin
      click(1'b1, 5);
      checks++;
      if ({target_width, at_max} !== {20'd1250, 1'b1}) begin
        errors++;
        $display("FAIL sat_up_%0d: got target=%0d max=%b expected 1250/1", c, target_width, at_max);
      end
    end
    click(1'b0, 5);
    checks++;
    if ({target_width, at_max, at_min} !== {20'd1050, 2'b00}) begin
      errors++;
      $display("FAIL sat_down: got target=%0d max/min=%b expected 1050/00", target_width, {at_max, at_min});
    end
  endtask

  task automatic test_lock;
    btn_up_n = 1'b0; btn_down_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (target_width !== 20'd1050) begin errors++; $display("FAIL lock_both: got %0d expected 1050", target_width); end
    btn_up_n = 1'b1;
    repeat (400) @(negedge clk);
    checks++;
    if (target_width !== 20'd1050) begin errors++; $display("FAIL lock_down_only: got %0d expected 1050", target_width); end
    btn_down_n = 1'b1;
    repeat (2) @(negedge clk);
    click(1'b0, 5);
    checks++;
    if (target_width !== 20'd850) begin errors++; $display("FAIL lock_exit: got %0d expected 850", target_width); end
    btn_down_n = 1'b0;
    @(negedge clk);
    checks++;
    if (target_width !== 20'd650) begin errors++; $display("FAIL held_step: got %0d expected 650", target_width); end
    btn_up_n = 1'b0;
    repeat (400) @(negedge clk);
    btn_up_n = 1'b1;
    repeat (400) @(negedge clk);
    checks++;
    if (target_width !== 20'd650) begin errors++; $display("FAIL held_to_lock: got %0d expected 650", target_width); end
    btn_down_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pulse_width, target_width, at_min, at_max, busy, frame_start} !==
        {20'd250, 20'd250, 4'b1000}) begin
      errors++;
      $display("FAIL async_reset: got pulse=%0d target=%0d flags=%b expected 250/250/1000",
               pulse_width, target_width, {at_min, at_max, busy, frame_start});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    btn_down_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({target_width, at_min, busy} !== {20'd250, 2'b10}) begin
      errors++;
      $display("FAIL down_at_min: got target=%0d min/busy=%b expected 250/10", target_width, {at_min, busy});
    end
    repeat (3) @(negedge clk);
    btn_down_n = 1'b1;
    repeat (2) @(negedge clk);
    click(1'b1, 3);
`ifdef SERVO_SLEW_EN
    p2 = 300;
`else
    p2 = 450;
`endif
    wait_frame(n);
    wait_frame(n);
    @(negedge clk);
    checks++;
    if (pulse_width !== 20'(p2)) begin errors++; $display("FAIL pre_disable: got %0d expected %0d", pulse_width, p2); end
    enable = 1'b0;
    bad = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (i == 100) btn_up_n = 1'b0;
      if (i == 150) btn_up_n = 1'b1;
      if (frame_start !== 1'b0 || pulse_width !== 20'(p2) || target_width !== 20'd450) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL disabled_freeze: got %0d bad cycles expected 0", bad); end
    enable = 1'b1;
    wait_frame(n);
    checks++;
    if (n !== P) begin errors++; $display("FAIL reenable_frame: got %0d cycles expected %0d", n, P); end
    btn_up_n = 1'b0;
    @(negedge clk);
`ifdef SERVO_SLEW_EN
    exp = 325;
`else
    exp = 450;
`endif
    checks++;
    if ({target_width, pulse_width, busy} !== {20'd650, 20'(exp), 1'b1}) begin
      errors++;
      $display("FAIL step_on_frame: got target=%0d pulse=%0d busy=%b expected 650/%0d/1",
               target_width, pulse_width, busy, exp);
    end
    btn_up_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_click();
    test_hold();
    test_saturate();
    test_lock();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_position_ctrl.md
Name: servo_position_ctrl

Overview:
- Command stage directly upstream of the servo PWM generator.
- Turns debounced, active-low up/down pushbutton levels into a saturated target pulse width, with click stepping and hold-to-autorepeat.
- Slews the output pulse width toward the target once per 20 ms frame.
- Emits a frame-start strobe so the PWM stage can latch a new width glitch-free at its period boundary.

Parameters:
- PERIOD, 1_000_000, frame length in clk cycles (20 ms at 50 MHz).
- PULSE_MIN, 25_000, minimum pulse width in clk cycles (0.5 ms).
- PULSE_MAX, 125_000, maximum pulse width in clk cycles (2.5 ms).
- STEP, 20_000, target change per accepted click or repeat (20 % of span).
- SLEW, 2_500, maximum change of pulse_width per frame.
- HOLD_CYC, 25_000_000, press duration before autorepeat starts (0.5 s).
- REPEAT_CYC, 5_000_000, interval between autorepeat steps (0.1 s).

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  block enable (slide switch, already synchronised).
- btn_up_n  in  1  debounced up button, 0 = pressed.
- btn_down_n  in  1  debounced down button, 0 = pressed.
- pulse_width  out  20  width for the PWM stage, changes only on frame_start.
- target_width  out  20  commanded width.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- at_min  out  1  target_width == PULSE_MIN.
- at_max  out  1  target_width == PULSE_MAX.
- busy  out  1  pulse_width != target_width.

Behaviour:
- Reset (async, rst_n low): pulse_width = target_width = PULSE_MIN; frame counter = 0; frame_start = 0; button FSM = IDLE; at_min = 1; at_max = 0; busy = 0. Exit from reset is synchronous to clk.
- Frame counter: counts 0..PERIOD-1 and wraps. frame_start is registered and is 1 in the cycle where the counter == 0.
- enable low:
  - Frame counter held at 0; frame_start = 0.
  - Button FSM forced to IDLE; timer cleared.
  - target_width and pulse_width hold their values.
- enable rising: the first frame_start occurs PERIOD cycles later.
- Button FSM (one shared hold timer):
  - IDLE:
    - Exactly one button pressed → issue one step (up: +STEP, down: −STEP), clear timer, go to HELD.
    - Both pressed → go to LOCK, no step.
  - HELD:
    - Timer reaches HOLD_CYC-1 → issue step, clear timer, go to REPEAT.
    - Pressed button released → IDLE.
    - Other button also pressed → LOCK.
  - REPEAT:
    - Every REPEAT_CYC cycles → issue step.
    - Release → IDLE.
    - Both pressed → LOCK.
  - LOCK: stay until both buttons are released, then IDLE. No steps in LOCK.
- Step arithmetic:
  - Performed at 21-bit width, then saturated into [PULSE_MIN, PULSE_MAX]. Up from 115_000 gives 125_000, not 135_000. Down from PULSE_MIN stays at PULSE_MIN.
  - A step takes effect on target_width the cycle after the triggering edge or timer expiry (1-cycle latency).
- Slew, applied only in the frame_start cycle:
  - If |target − pulse_width| ≤ SLEW → pulse_width = target.
  - Otherwise pulse_width moves SLEW toward the target.
  - Update is visible the cycle after frame_start.
  - A step and a frame_start in the same cycle: slew uses the old target.
- at_min, at_max, busy: registered, derived from the values being written that cycle, so they are coherent with target_width and pulse_width.
- Parameter constraint: PULSE_MAX < PERIOD. A violating set must fail elaboration.

Optional Feature:
- SERVO_SLEW_EN defined: slew limiting as described.
- Not defined: pulse_width copies target_width on every frame_start in one step; busy is high only between a step and the next frame_start; the SLEW parameter is unused.

Decomposition:
- Package servo_pkg:
  - Width constant W = 20.
  - Button FSM state enum {IDLE, HELD, REPEAT, LOCK}.
  - Default timing constants (PERIOD, PULSE_MIN, PULSE_MAX).
  - Shared by this block and the PWM stage.
- One sub-module, servo_btn_fsm: button FSM plus hold/repeat timer. Outputs step_up and step_dn single-cycle pulses.
- Frame counter, saturation and slew stay in the top.

Test Plan:
- Reset release, no buttons → pulse_width = 25_000, at_min = 1, frame_start every 1_000_000 cycles.
- Single up click of 1 ms, SERVO_SLEW_EN on → target = 45_000 next cycle; pulse_width reaches 27_500, 30_000 … 45_000 over 8 frames; busy falls at the 8th frame.
- Up held 0.75 s → steps at t=0, 0.5 s and 0.6 s; target reaches 85_000 and stays there until 0.7 s.
- Target 115_000, two up clicks → target = 125_000, at_max = 1, no overflow.
- Both buttons pressed, then up released while down still held → no step at any point; LOCK held until both are released.
- enable dropped mid-ramp (pulse 30_000, target 45_000) → frame_start stops, both values frozen. Re-enable → ramp resumes PERIOD cycles later. Async rst_n low mid-frame → outputs return to reset values immediately.
